// File: rtl/apb_stream_pkg.sv
// Shared types and field positions for the APB stream initiator.
package apb_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StSetup,
    StAccess,
    StRdout,
    StDrain,
    StStatus
  } state_e;

  // Command header fields
  localparam int unsigned HdrWriteBit = 31;
  localparam int unsigned HdrCountLsb = 16;

  // Status word fields
  localparam int unsigned StsErrBit     = 31;
  localparam int unsigned StsFrameBit   = 30;
  localparam int unsigned StsTimeoutBit = 29;
  localparam int unsigned StsCountLsb   = 16;
  localparam int unsigned StsFirstLsb   = 0;

  localparam logic [3:0] PSTRB_ALL = 4'hf;

  function automatic logic [31:0] status_word(input logic       err,
                                              input logic       frm,
                                              input logic       tmo,
                                              input logic [7:0] cnt,
                                              input logic [7:0] first);
    logic [31:0] w;
    w = '0;
    w[StsErrBit]            = err;
    w[StsFrameBit]          = frm;
    w[StsTimeoutBit]        = tmo;
    w[StsCountLsb +: 8]     = cnt;
    w[StsFirstLsb +: 8]     = first;
    return w;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles; flags expiry on the last allowed cycle.
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Clear has priority; saturate once expired so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_stream_initiator.sv
// Command-stream driven APB requester: header/address/data frames in,
// read data words plus one status word out.
module apb_stream_initiator
  import apb_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hdead_beef
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [31:0]           rx_data,
  input  logic                  rx_last,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [31:0]           tx_data,
  output logic                  tx_last,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [7:0]            n_q, n_d;           // N-1
  logic [7:0]            idx_q, idx_d;       // index of current transfer
  logic                  err_q, err_d;
  logic                  frm_q, frm_d;
  logic                  tmo_q, tmo_d;
  logic                  drain_q, drain_d;   // discard trailing beats before STATUS
  logic                  stop_q, stop_d;     // early rx_last: no further transfers
  logic [7:0]            first_err_q, first_err_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic [31:0]           tx_data_q, tx_data_d;

  logic rx_hs, last_xfer, expired, xfer_done, timed_out, xfer_err;

  assign rx_hs     = rx_valid && rx_ready_q;
  assign last_xfer = (idx_q == n_q);
  assign xfer_done = pready || expired;
  assign timed_out = expired && !pready;
  assign xfer_err  = (pready && pslverr) || timed_out;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == StSetup),
    .enable (state_q == StAccess),
    .expired(expired)
  );

  // Next state, command bookkeeping and registered output values
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    n_d         = n_q;
    idx_d       = idx_q;
    err_d       = err_q;
    frm_d       = frm_q;
    tmo_d       = tmo_q;
    drain_d     = drain_q;
    stop_d      = stop_q;
    first_err_d = first_err_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    tx_data_d   = tx_data_q;

    unique case (state_q)
      StIdle: begin
        if (rx_hs) begin
          write_d     = rx_data[HdrWriteBit];
          n_d         = rx_data[HdrCountLsb +: 8];
          idx_d       = '0;
          err_d       = 1'b0;
          frm_d       = 1'b0;
          tmo_d       = 1'b0;
          drain_d     = 1'b0;
          stop_d      = 1'b0;
          first_err_d = '0;
          if (rx_last) begin
            frm_d   = 1'b1;
            state_d = StStatus;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (rx_hs) begin
          paddr_d = rx_data[ADDR_WIDTH-1:0];
          if (write_q) begin
            if (rx_last) begin
              frm_d   = 1'b1;
              state_d = StStatus;
            end else begin
              state_d = StWdata;
            end
          end else begin
            if (!rx_last) begin
              frm_d   = 1'b1;
              drain_d = 1'b1;
            end
            state_d = StSetup;
          end
        end
      end
      StWdata: begin
        if (rx_hs) begin
          pwdata_d = rx_data;
          // A frame that ends early still writes the word that carried rx_last.
          if (rx_last && !last_xfer) begin
            frm_d  = 1'b1;
            stop_d = 1'b1;
          end
          if (!rx_last && last_xfer) begin
            frm_d   = 1'b1;
            drain_d = 1'b1;
          end
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (xfer_done) begin
          if (xfer_err) begin
            err_d = 1'b1;
            if (!err_q) first_err_d = idx_q;
          end
          if (timed_out) tmo_d = 1'b1;
          if (!write_q) begin
            tx_data_d = timed_out ? TIMEOUT_DATA : prdata;
            state_d   = StRdout;
          end else if (last_xfer || stop_q) begin
            state_d = drain_q ? StDrain : StStatus;
          end else begin
            idx_d   = idx_q + 8'd1;
            paddr_d = paddr_q + ADDR_WIDTH'(4);
            state_d = StWdata;
          end
        end
      end
      StRdout: begin
        if (tx_ready) begin
          if (last_xfer) begin
            state_d = drain_q ? StDrain : StStatus;
          end else begin
            idx_d   = idx_q + 8'd1;
            paddr_d = paddr_q + ADDR_WIDTH'(4);
            state_d = StSetup;
          end
        end
      end
      StDrain: begin
        if (rx_hs && rx_last) state_d = StStatus;
      end
      StStatus: begin
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StStatus) begin
      tx_data_d = status_word(err_d, frm_d, tmo_d, n_d, first_err_d);
    end

    rx_ready_d = (state_d == StIdle) || (state_d == StAddr) ||
                 (state_d == StWdata) || (state_d == StDrain);
    psel_d     = (state_d == StSetup) || (state_d == StAccess);
    penable_d  = (state_d == StAccess);
    pwrite_d   = psel_d && write_d;
    pstrb_d    = (psel_d && write_d) ? PSTRB_ALL : 4'h0;
    tx_valid_d = (state_d == StRdout) || (state_d == StStatus);
    tx_last_d  = (state_d == StStatus);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      n_q         <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      frm_q       <= 1'b0;
      tmo_q       <= 1'b0;
      drain_q     <= 1'b0;
      stop_q      <= 1'b0;
      first_err_q <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      frm_q       <= frm_d;
      tmo_q       <= tmo_d;
      drain_q     <= drain_d;
      stop_q      <= stop_d;
      first_err_q <= first_err_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign tx_data  = tx_data_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pstrb    = pstrb_q;

endmodule

// File: tb/tb_apb_stream_initiator.sv
// Directed bench for apb_stream_initiator with a small APB slave model.
module tb_apb_stream_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_ready, rx_last;
  logic [31:0] rx_data;
  logic        tx_valid, tx_ready, tx_last;
  logic [31:0] tx_data;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  apb_stream_initiator #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_DATA  (32'hdead_beef)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_data (rx_data),
    .rx_last (rx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Slave configuration and transfer log
  int          cfg_wait = 0;
  int          cfg_err_idx = -1;
  bit          cfg_hang = 1'b0;
  int          xfer_n = 0;
  int          setup_cycles = 0;
  int          acc_len = 0;
  int          last_acc_len = 0;
  int          wait_cnt = 0;
  logic [31:0] log_addr[32];
  logic [31:0] log_wdata[32];
  logic        log_write[32];
  logic [3:0]  log_strb[32];

  logic [32:0] rq[$];

  // Response collector: a handshake is certain once valid&ready hold mid-cycle
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) rq.push_back({tx_last, tx_data});
  end

  // APB slave: answers with addr^ffffffff after cfg_wait wait states
  initial begin
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      if (psel && !penable) setup_cycles++;
      if (psel && penable) begin
        acc_len++;
        if (!cfg_hang && wait_cnt >= cfg_wait) begin
          pready  = 1'b1;
          prdata  = paddr ^ 32'hffff_ffff;
          pslverr = (xfer_n == cfg_err_idx);
          if (xfer_n < 32) begin
            log_addr[xfer_n]  = paddr;
            log_wdata[xfer_n] = pwdata;
            log_write[xfer_n] = pwrite;
            log_strb[xfer_n]  = pstrb;
          end
          xfer_n++;
        end
        wait_cnt++;
      end else begin
        if (acc_len > 0) last_acc_len = acc_len;
        acc_len  = 0;
        wait_cnt = 0;
      end
    end
  end

  task automatic start_test();
    rq.delete();
    xfer_n = 0; setup_cycles = 0; last_acc_len = 0;
    cfg_wait = 0; cfg_err_idx = -1; cfg_hang = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d; rx_last = l;
    while (!rx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check_eq("rx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int n);
    int t = 0;
    while (rq.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check_eq({tag, "_nwords"}, rq.size(), n);
  endtask

  task automatic check_resp(input string tag, input int i, input logic [31:0] d, input logic l);
    logic [32:0] w;
    w = (i < rq.size()) ? rq[i] : 33'h0_baad_f00d;
    check_eq($sformatf("%s_w%0d_data", tag, i), w[31:0], d);
    check_eq($sformatf("%s_w%0d_last", tag, i), {31'd0, w[32]}, {31'd0, l});
  endtask

  task automatic check_xfer(input string tag, input int i, input logic [31:0] a,
                            input logic wr, input logic [31:0] wd);
    check_eq($sformatf("%s_x%0d_addr", tag, i), log_addr[i], a);
    check_eq($sformatf("%s_x%0d_write", tag, i), {31'd0, log_write[i]}, {31'd0, wr});
    check_eq($sformatf("%s_x%0d_strb", tag, i), {28'd0, log_strb[i]}, wr ? 32'hf : 32'h0);
    if (wr) check_eq($sformatf("%s_x%0d_wdata", tag, i), log_wdata[i], wd);
  endtask

  initial begin
    int t;
    int viol;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_tx_last", {31'd0, tx_last}, 32'd0);
    check_eq("rst_tx_data", tx_data, 32'd0);
    check_eq("rst_psel_penable_pwrite", {29'd0, psel, penable, pwrite}, 32'd0);
    check_eq("rst_paddr", paddr, 32'd0);
    check_eq("rst_pwdata", pwdata, 32'd0);
    check_eq("rst_pstrb", {28'd0, pstrb}, 32'd0);
    rst = 1'b0;

    // Single write
    start_test();
    send_word(32'h8000_0000, 1'b0);
    send_word(32'h0000_0400, 1'b0);
    send_word(32'h1234_5678, 1'b1);
    wait_resp("wr1", 1);
    check_resp("wr1", 0, 32'h0000_0000, 1'b1);
    check_eq("wr1_xfers", xfer_n, 1);
    check_xfer("wr1", 0, 32'h0000_0400, 1'b1, 32'h1234_5678);
    check_eq("wr1_setup_cycles", setup_cycles, 1);
    check_eq("wr1_access_cycles", last_acc_len, 1);

    // Read burst of 4 with 2 wait states
    start_test();
    cfg_wait = 2;
    send_word(32'h0003_0000, 1'b0);
    send_word(32'h0000_1000, 1'b1);
    wait_resp("rd4", 5);
    check_resp("rd4", 0, 32'hffff_efff, 1'b0);
    check_resp("rd4", 1, 32'hffff_effb, 1'b0);
    check_resp("rd4", 2, 32'hffff_eff7, 1'b0);
    check_resp("rd4", 3, 32'hffff_eff3, 1'b0);
    check_resp("rd4", 4, 32'h0003_0000, 1'b1);
    for (int i = 0; i < 4; i++) check_xfer("rd4", i, 32'h1000 + 32'(4 * i), 1'b0, 32'd0);
    check_eq("rd4_setup_cycles", setup_cycles, 4);
    check_eq("rd4_access_cycles", last_acc_len, 3);

    // Slave error on transfer 1 of 3
    start_test();
    cfg_err_idx = 1;
    send_word(32'h0002_0000, 1'b0);
    send_word(32'h0000_2000, 1'b1);
    wait_resp("err", 4);
    check_eq("err_xfers", xfer_n, 3);
    check_resp("err", 2, 32'hffff_dff7, 1'b0);
    check_resp("err", 3, 32'h8002_0001, 1'b1);

    // Timeout: pready never comes
    start_test();
    cfg_hang = 1'b1;
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h0000_3000, 1'b1);
    wait_resp("tmo", 2);
    check_resp("tmo", 0, 32'hdead_beef, 1'b0);
    check_resp("tmo", 1, 32'ha000_0000, 1'b1);
    check_eq("tmo_access_cycles", last_acc_len, 16);

    // Write N=3 ending early on the second data word
    start_test();
    send_word(32'h8002_0000, 1'b0);
    send_word(32'h0000_4000, 1'b0);
    send_word(32'h0000_000a, 1'b0);
    send_word(32'h0000_000b, 1'b1);
    wait_resp("frm", 1);
    check_resp("frm", 0, 32'h4002_0000, 1'b1);
    check_eq("frm_xfers", xfer_n, 2);
    check_xfer("frm", 0, 32'h0000_4000, 1'b1, 32'h0000_000a);
    check_xfer("frm", 1, 32'h0000_4004, 1'b1, 32'h0000_000b);
    rq.delete();
    send_word(32'h8000_0000, 1'b0);
    send_word(32'h0000_5000, 1'b0);
    send_word(32'h0000_000c, 1'b1);
    wait_resp("frm_next", 1);
    check_resp("frm_next", 0, 32'h0000_0000, 1'b1);
    check_eq("frm_next_xfers", xfer_n, 3);
    check_xfer("frm_next", 2, 32'h0000_5000, 1'b1, 32'h0000_000c);

    // Response backpressure during a read burst of 2
    start_test();
    @(posedge clk); #1;
    tx_ready = 1'b0;
    send_word(32'h0001_0000, 1'b0);
    send_word(32'h0000_6000, 1'b1);
    t = 0;
    while (!tx_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (psel) viol++;
    end
    check_eq("bp_psel_while_stalled", viol, 0);
    check_eq("bp_xfers_while_stalled", xfer_n, 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_resp("bp", 3);
    check_resp("bp", 0, 32'hffff_9fff, 1'b0);
    check_resp("bp", 1, 32'hffff_9ffb, 1'b0);
    check_resp("bp", 2, 32'h0001_0000, 1'b1);

    // Read address beat without rx_last: trailing beat is drained
    start_test();
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h0000_7000, 1'b0);
    send_word(32'h0000_0099, 1'b1);
    wait_resp("drain", 2);
    check_resp("drain", 0, 32'hffff_8fff, 1'b0);
    check_resp("drain", 1, 32'h4000_0000, 1'b1);
    check_eq("drain_xfers", xfer_n, 1);

    // Reset during ACCESS drops the bus the next cycle
    start_test();
    cfg_hang = 1'b1;
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h0000_8000, 1'b1);
    t = 0;
    while (!penable && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_rst_in_access", {31'd0, penable}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_psel_penable", {30'd0, psel, penable}, 32'd0);
    check_eq("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
